hazard_tracker: RTL and testbench
=================================

// Module: hazard_tracker
// PURPOSE
//  Stall/forward controller for the pipelined MIPS core, parametrised in tracked pipeline depth.
//  - Keeps a per-stage record of in-flight register writers: dest A3 and remaining Tnew.
//  - Compares the D-stage instruction's Tuse_Rs/Tuse_Rt (from the instruction decoder) against it.
//  - Outputs stall and per-source forward selects.
//  - Adds a multi-cycle mult/div busy counter that interlocks HI/LO users.
// PARAMETERS
//  STAGES   3   post-decode stages tracked (E=1, M=2, W=3, ...); min 1
//  TW       3   width of Tnew/Tuse fields; all-ones Tuse = "source not read"
//  MUL_LAT  5   busy cycles after a mult/multu issues
//  DIV_LAT  10  busy cycles after a div/divu issues
//  SELW     $clog2(STAGES+1)  forward-select width (localparam)
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     synchronous, active-low reset
//  d_valid    in   1     D-stage holds a real instruction
//  d_rs       in   5     D rs address
//  d_rt       in   5     D rt address
//  d_tuse_rs  in   TW    cycles until rs is consumed; all-ones = unused
//  d_tuse_rt  in   TW    as above for rt
//  d_wen      in   1     D instruction writes GPR
//  d_a3       in   5     D write address
//  d_tnew     in   TW    Tnew the D instruction will have on entering E
//  d_md_start in   1     D is mult/multu/div/divu
//  d_md_div   in   1     with d_md_start: 1 = divide latency
//  d_md_use   in   1     D reads/writes HI/LO or starts the MDU
//  stall      out  1     freeze PC/D, insert bubble into E
//  fwd_rs     out  SELW  0 = regfile, k = stage k pipeline register
//  fwd_rt     out  SELW  as above for rt
//  md_busy    out  1     MDU counter non-zero
// BEHAVIOUR
//  - State: entry[1..STAGES] = {wv, a3[4:0], tnew[TW-1:0]}; md_cnt counter.
//  - Each clk: entry[k+1] <= {entry[k].wv, entry[k].a3, sat_dec(entry[k].tnew)}.
//    sat_dec(0) = 0; entry[STAGES] is discarded.
//  - entry[1] <= stall ? 0 : {d_valid & d_wen & (d_a3!=0), d_a3, d_tnew}.
//  - Per source s (rs/rt): hazard checked only if d_valid, addr != 0 and tuse != all-ones.
//    - m = lowest k with entry[k].wv & entry[k].a3 == addr; youngest match wins, older ones ignored.
//    - entry[m].tnew > tuse           -> stall.
//    - entry[m].tnew == 0             -> fwd_s = m.
//    - else (0 < tnew <= tuse) or no match -> fwd_s = 0; later stage forwards.
//  - MDU interlock:
//    - stall also = d_valid & d_md_use & md_busy.
//    - On edge with d_valid & d_md_start & ~stall: md_cnt <= d_md_div ? DIV_LAT : MUL_LAT.
//    - Otherwise md_cnt <= md_cnt - (md_cnt != 0).
//    - md_busy = (md_cnt != 0); busy exactly LAT cycles after the issue edge.
//  - stall/fwd are combinational from state + D inputs. Zero-latency: stall asserts the same cycle.
//  - Reset (reset==0 at edge): all entries 0, md_cnt 0.
//    - stall, fwd_rs, fwd_rt and md_busy are forced 0 while reset is low.
//    - A mid-operation reset discards in-flight writers and any pending MDU count.
//  - rs == rt: both sources are evaluated independently; the selects may match.
//  - stall asserted by both GPR and MDU causes in the same cycle is a single stall.
// CONFIGURATION
//  HAZARD_STATS_EN
//  - defined: extra output stall_cnt out 32.
//    - Increments each cycle stall==1; saturates at 32'hFFFF_FFFF; 0 on reset.
//  - undefined: port and counter absent; behaviour otherwise identical.
// TESTING (STAGES=3, TW=3, MUL_LAT=5, DIV_LAT=10)
//  1. reset low 2 cycles, d_valid=1 d_wen=1 d_a3=9
//     -> stall=0 fwd=0 md_busy=0.
//     Release, then beq rs=9 tuse=0 -> no stall (entries empty).
//  2. ori a3=10 tnew=1, next cycle beq rs=10 tuse_rs=0
//     -> cycle2 stall=1; cycle3 stall=0, fwd_rs=2.
//  3. lw a3=11 tnew=2, next cycle addu rs=11 tuse=1
//     -> cycle2 stall=1; cycle3 stall=0, fwd_rs=0 (E forwards).
//  4. addu a3=0 tnew=1, then beq rs=0 -> never stalls, fwd 0.
//     addu a3=8, addu a3=8, beq rs=8 -> fwd_rs selects the youngest match only.
//  5. mult issue, next cycle mflo (md_use=1) -> md_busy high 5 cycles, mflo stalled 5 cycles.
//     div issue -> 10 cycles busy.
//     Reset mid-count -> md_busy=0 next cycle.
//  6. HAZARD_STATS_EN defined, rerun scenario 2+5 -> stall_cnt == 6.
//     Reset -> 0.

Source files
------------

// File: rtl/hazard_tracker.sv
// Stall/forward controller for a pipelined MIPS core with a multi-cycle MDU interlock.
// Optional build macro HAZARD_STATS_EN adds a saturating stall_cnt output.
module hazard_tracker #(
    parameter int STAGES  = 3,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int SELW   = $clog2(STAGES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic            d_wen,
    input  logic [4:0]      d_a3,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md_start,
    input  logic            d_md_div,
    input  logic            d_md_use,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs,
    output logic [SELW-1:0] fwd_rt,
    output logic            md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic            ent_wv   [1:STAGES];
    logic [4:0]      ent_a3   [1:STAGES];
    logic [TW-1:0]   ent_tnew [1:STAGES];
    logic [CW-1:0]   md_cnt;

    logic [SELW:0]   res_rs;
    logic [SELW:0]   res_rt;
    logic            md_stall;
    logic            raw_stall;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Result is {stall, select}; scanning oldest-to-youngest lets the youngest match win.
    function automatic logic [SELW:0] eval_src(input logic          valid,
                                               input logic [4:0]    addr,
                                               input logic [TW-1:0] tuse);
        logic            hit;
        logic            chk;
        logic [TW-1:0]   t;
        logic [SELW-1:0] idx;
        hit = 1'b0;
        t   = '0;
        idx = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (ent_wv[k] && (ent_a3[k] == addr)) begin
                hit = 1'b1;
                t   = ent_tnew[k];
                idx = SELW'(k);
            end
        end
        chk = valid && (addr != 5'd0) && (tuse != '1);
        return {chk && hit && (t > tuse), (chk && hit && (t == '0)) ? idx : '0};
    endfunction

    always_comb begin
        res_rs    = eval_src(d_valid, d_rs, d_tuse_rs);
        res_rt    = eval_src(d_valid, d_rt, d_tuse_rt);
        md_stall  = d_valid && d_md_use && (md_cnt != '0);
        raw_stall = res_rs[SELW] || res_rt[SELW] || md_stall;
        stall     = reset && raw_stall;
        fwd_rs    = reset ? res_rs[SELW-1:0] : '0;
        fwd_rt    = reset ? res_rt[SELW-1:0] : '0;
        md_busy   = reset && (md_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                ent_wv[k]   <= 1'b0;
                ent_a3[k]   <= '0;
                ent_tnew[k] <= '0;
            end
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                ent_wv[k]   <= ent_wv[k-1];
                ent_a3[k]   <= ent_a3[k-1];
                ent_tnew[k] <= sat_dec(ent_tnew[k-1]);
            end
            // A stalled D becomes a bubble in E.
            if (stall) begin
                ent_wv[1]   <= 1'b0;
                ent_a3[1]   <= '0;
                ent_tnew[1] <= '0;
            end else begin
                ent_wv[1]   <= d_valid && d_wen && (d_a3 != 5'd0);
                ent_a3[1]   <= d_a3;
                ent_tnew[1] <= d_tnew;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (d_valid && d_md_start && !stall) begin
            md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker (STAGES=3, TW=3, MUL_LAT=5, DIV_LAT=10).
// The stall_cnt scenario is exercised only when HAZARD_STATS_EN is defined.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [2:0] d_tuse_rs;
    logic [2:0] d_tuse_rt;
    logic       d_wen;
    logic [4:0] d_a3;
    logic [2:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_tracker #(.STAGES(3), .TW(3), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wen(d_wen), .d_a3(d_a3),
        .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive_idle;
        d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3'b111; d_tuse_rt = 3'b111;
        d_wen = 0; d_a3 = 0; d_tnew = 0; d_md_start = 0; d_md_div = 0; d_md_use = 0;
    endtask

    task automatic writer(input logic [4:0] a3, input logic [2:0] tnew);
        drive_idle();
        d_valid = 1; d_wen = 1; d_a3 = a3; d_tnew = tnew;
    endtask

    task automatic reader(input logic [4:0] rs, input logic [2:0] trs,
                          input logic [4:0] rt, input logic [2:0] trt);
        drive_idle();
        d_valid = 1; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    endtask

    task automatic flush;
        drive_idle();
        repeat (3) tick();
    endtask

    task automatic test_reset;
        reset = 0;
        writer(5'd9, 3'd1);
        d_rs = 5'd9; d_tuse_rs = 3'd0;
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
            total++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin bad++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_rs, fwd_rt); end
            total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", md_busy); end
        end
        reset = 1;
        reader(5'd9, 3'd0, 5'd0, 3'b111);
        settle();
        total++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin bad++; $display("FAIL reset_release: stall=%0b fwd_rs=%0d want 0/0", stall, fwd_rs); end
        tick();
        flush();
    endtask

    task automatic test_gpr_stall;
        writer(5'd10, 3'd1);
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ori_issue: stall=%0b want 0", stall); end
        tick();
        reader(5'd10, 3'd0, 5'd0, 3'd0);
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL beq_c2_stall: stall=%0b want 1", stall); end
        tick(); settle();
        total++; if (stall !== 1'b0 || fwd_rs !== 2'd2) begin bad++; $display("FAIL beq_c3: stall=%0b fwd_rs=%0d want 0/2", stall, fwd_rs); end
        tick();
        flush();
    endtask

    task automatic test_load_use;
        writer(5'd11, 3'd2);
        tick();
        reader(5'd11, 3'd1, 5'd0, 3'b111);
        d_wen = 1; d_a3 = 5'd13; d_tnew = 3'd1;
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_use_c2: stall=%0b want 1", stall); end
        tick(); settle();
        total++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin bad++; $display("FAIL lw_use_c3: stall=%0b fwd_rs=%0d want 0/0", stall, fwd_rs); end
        tick();
        flush();
    endtask

    task automatic test_zero_and_youngest;
        writer(5'd0, 3'd1);
        tick();
        reader(5'd0, 3'd0, 5'd0, 3'd0);
        settle();
        total++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin bad++; $display("FAIL r0_dest: stall=%0b fwd_rs=%0d want 0/0", stall, fwd_rs); end
        flush();
        writer(5'd8, 3'd1);
        tick();
        writer(5'd8, 3'd1);
        tick();
        // Older copy already has tnew 0, but the younger (tnew 1) must decide.
        reader(5'd8, 3'd1, 5'd0, 3'b111);
        settle();
        total++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin bad++; $display("FAIL youngest_tuse1: stall=%0b fwd_rs=%0d want 0/0", stall, fwd_rs); end
        d_valid = 0;
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL invalid_d: stall=%0b want 0", stall); end
        reader(5'd8, 3'd0, 5'd0, 3'b111);
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL youngest_tuse0: stall=%0b want 1", stall); end
        tick(); settle();
        total++; if (stall !== 1'b0 || fwd_rs !== 2'd2) begin bad++; $display("FAIL youngest_fwd: stall=%0b fwd_rs=%0d want 0/2", stall, fwd_rs); end
        tick();
        flush();
    endtask

    task automatic test_same_src;
        writer(5'd12, 3'd1);
        tick();
        drive_idle();
        tick();
        reader(5'd12, 3'd1, 5'd12, 3'd1);
        settle();
        total++; if (fwd_rs !== 2'd2 || fwd_rt !== 2'd2) begin bad++; $display("FAIL same_src_m: fwd=%0d/%0d want 2/2", fwd_rs, fwd_rt); end
        tick(); settle();
        total++; if (fwd_rs !== 2'd3 || fwd_rt !== 2'd3) begin bad++; $display("FAIL same_src_w: fwd=%0d/%0d want 3/3", fwd_rs, fwd_rt); end
        tick(); settle();
        total++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0 || stall !== 1'b0) begin bad++; $display("FAIL same_src_gone: fwd=%0d/%0d stall=%0b want 0/0/0", fwd_rs, fwd_rt, stall); end
        flush();
    endtask

    task automatic test_mdu_mult;
        drive_idle();
        d_valid = 1; d_md_start = 1; d_md_use = 1;
        settle();
        total++; if (stall !== 1'b0 || md_busy !== 1'b0) begin bad++; $display("FAIL mult_issue: stall=%0b busy=%0b want 0/0", stall, md_busy); end
        tick();
        writer(5'd14, 3'd1);
        d_md_use = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            total++; if (stall !== 1'b1 || md_busy !== 1'b1) begin bad++; $display("FAIL mflo_wait%0d: stall=%0b busy=%0b want 1/1", i, stall, md_busy); end
            tick();
        end
        settle();
        total++; if (stall !== 1'b0 || md_busy !== 1'b0) begin bad++; $display("FAIL mflo_go: stall=%0b busy=%0b want 0/0", stall, md_busy); end
        tick();
        flush();
    endtask

    task automatic test_mdu_div;
        drive_idle();
        d_valid = 1; d_md_start = 1; d_md_div = 1; d_md_use = 1;
        tick();
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            settle();
            total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL div_busy%0d: busy=%0b want 1", i, md_busy); end
            tick();
        end
        settle();
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL div_done: busy=%0b want 0", md_busy); end
        flush();
    endtask

    task automatic test_mid_reset;
        drive_idle();
        d_valid = 1; d_md_start = 1; d_md_use = 1;
        tick();
        writer(5'd15, 3'd1);
        settle();
        total++; if (md_busy !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL midrst_pre: busy=%0b stall=%0b want 1/0", md_busy, stall); end
        tick();
        reader(5'd15, 3'd0, 5'd0, 3'b111);
        d_md_use = 1;
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL midrst_both: stall=%0b want 1", stall); end
        reset = 0;
        settle();
        total++; if (stall !== 1'b0 || md_busy !== 1'b0 || fwd_rs !== 2'd0) begin bad++; $display("FAIL midrst_forced: stall=%0b busy=%0b fwd_rs=%0d want 0/0/0", stall, md_busy, fwd_rs); end
        tick();
        reset = 1;
        settle();
        total++; if (stall !== 1'b0 || md_busy !== 1'b0) begin bad++; $display("FAIL midrst_after: stall=%0b busy=%0b want 0/0", stall, md_busy); end
        tick();
        flush();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats;
        reset = 0;
        drive_idle();
        tick();
        reset = 1;
        test_gpr_stall();
        test_mdu_mult();
        settle();
        total++; if (stall_cnt !== 32'd6) begin bad++; $display("FAIL stall_cnt: got %0d want 6", stall_cnt); end
        reset = 0;
        tick(); settle();
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_cnt_rst: got %0d want 0", stall_cnt); end
        reset = 1;
        tick();
    endtask
`endif

    initial begin
        reset = 0;
        drive_idle();
        test_reset();
        test_gpr_stall();
        test_load_use();
        test_zero_and_youngest();
        test_same_src();
        test_mdu_mult();
        test_mdu_div();
        test_mid_reset();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
